rename_recovery_sequencer: RTL and testbench
============================================

Name: rename_recovery_sequencer

Overview:
- Control sequencer for the register renamer: post-reset init, retire-time freeing, flush-time rollback.
- Keeps a journal of in-flight renames. On retire it frees the previous physical register. On flush it walks the journal youngest-to-oldest, restoring spec-table mappings and returning speculative registers to the free lists.
- Sits between decode/issue/retire and the spec-table write port and GP/FP free-list push ports; replaces the renamer's ad-hoc init/rollback muxing.

Parameters:
- DEPTH, 32: journal entries, power of two, max in-flight renames.
- INCLUDE_FP, 1: sequence the FP table/free list as well as GP.
- ARCH_REGS, 32: architectural registers per file; physical addresses are 0..2*ARCH_REGS-1.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-low.
- rename_valid  in  1  decode renamed a non-x0 rd this cycle; push journal.
- rename_is_fp  in  1  rename targets the FP file.
- rename_rd  in  5  architectural rd.
- rename_phys  in  6  newly allocated physical register.
- rename_prev_phys  in  6  mapping being replaced.
- retire_valid  in  1  oldest journal entry commits.
- flush  in  1  discard all uncommitted journal entries.
- tbl_we  out  1  spec-table write strobe.
- tbl_is_fp  out  1  selects the FP table.
- tbl_waddr  out  5  table index.
- tbl_wdata  out  6  physical address written.
- free_push  out  1  free-list push strobe.
- free_is_fp  out  1  selects the FP free list.
- free_data  out  6  physical register returned.
- stall  out  1  decode must not rename.
- init_done  out  1  init complete.
- journal_full  out  1  count == DEPTH.

Behaviour:
- All outputs registered.
- Reset values: tbl_we=0, free_push=0, stall=1, init_done=0, journal_full=0, other outputs 0. Journal head, tail and count = 0. State INIT_GP, counter idx=0.
- INIT_GP, one cycle per idx 0..31:
  - tbl_we=1, tbl_is_fp=0, tbl_waddr=idx, tbl_wdata={0,idx}.
  - free_push=1, free_is_fp=0, free_data={1,idx}.
  - At idx=31: go to INIT_FP if INCLUDE_FP, else IDLE.
- INIT_FP: same as INIT_GP with both is_fp selects = 1; then IDLE.
- Init lengths: 32 cycles (GP only) or 64 cycles (with FP).
- init_done and stall=0 take effect the cycle after the last init write.
- Inputs during INIT are ignored.
- IDLE:
  - rename_valid pushes {is_fp, rd, phys, prev_phys} at the tail.
  - retire_valid pops the head. Next cycle: free_push=1, free_data=head.prev_phys, free_is_fp=head.is_fp, tbl_we=0.
  - Rename and retire in the same cycle: count unchanged.
- Flush in IDLE:
  - A retire_valid in the same cycle is processed first and its free is emitted next cycle.
  - Then stall=1 and the state goes to ROLLBACK, starting the cycle after.
  - A rename_valid in the flush cycle is dropped; it is part of the flushed path.
- ROLLBACK, one entry per cycle, youngest first (tail-1):
  - tbl_we=1, tbl_waddr=rd, tbl_wdata=prev_phys, tbl_is_fp=is_fp.
  - free_push=1, free_data=phys, free_is_fp=is_fp.
  - Decrement tail and count.
  - When count reaches 0: return to IDLE with stall=0 next cycle.
  - Flush with an empty journal: one idle cycle in ROLLBACK, then IDLE.
  - Latency = entries + 1 cycles.
- ROLLBACK error/ignore rules:
  - retire_valid during ROLLBACK is a protocol error; assert it never happens.
  - rename_valid during ROLLBACK is ignored and asserted.
  - flush during ROLLBACK is idempotent.
- Full and empty:
  - rename_valid while full (with no simultaneous retire) is dropped and asserted.
  - retire_valid while empty is ignored and asserted.
  - journal_full updates the cycle after count changes.
- Head and tail pointers wrap modulo DEPTH.
- rst low mid-operation: returns to INIT_GP with the journal cleared.

Optional Feature:
- Macro RENAME_RECOVERY_PERF_EN.
- Defined: adds output rollback_cycles (32 bits), a saturating count of cycles spent in ROLLBACK, and output flush_count (16 bits), a saturating count of flush entries into ROLLBACK. Both reset to 0.
- Undefined: neither port nor counter exists; behaviour is otherwise identical.

Decomposition:
- Shared package (cva5_types):
  - rename_journal_entry_t {is_fp, rd[4:0], phys[5:0], prev_phys[5:0]}.
  - rename_seq_state_t enum {INIT_GP, INIT_FP, IDLE, ROLLBACK}.
  - Existing phys_addr_t.
- One sub-module, rename_journal: circular buffer with push at tail, pop at head (retire) or at tail (rollback), count, full and empty. Head and tail reads are combinational.

Test Plan:
- Release reset with INCLUDE_FP=1 -> 64 consecutive tbl_we/free_push cycles. Cycle 0: tbl 0<-0, free 32. Cycle 63: FP tbl 31<-31, free 63. init_done=1 and stall=0 the next cycle.
- Rename rd=5 phys=40 prev=5, then retire -> one cycle after retire: free_push=1, free_data=5, free_is_fp=0; journal empty.
- Renames (rd3,p33,prev3), (rd3,p34,prev33), (FP rd7,p40,prev7), then flush -> three rollback cycles: FP tbl7<-7/free 40; tbl3<-33/free 34; tbl3<-3/free 33. stall=1 for 4 cycles.
- Retire and flush in the same cycle with 2 entries -> oldest freed first, then one rollback cycle for the remaining entry.
- Fill 32 renames -> journal_full=1. A 33rd rename alone is dropped; rename+retire in the same cycle is accepted and count stays 32. Wrap-around rollback restores correctly.
- Pull rst low midway through ROLLBACK -> outputs at reset values, INIT_GP restarts at idx 0, journal empty.

Source files
------------

// File: rtl/rename_recovery_sequencer_pkg.sv
// Shared types for the rename recovery sequencer: journal entry payload,
// sequencer state encoding and the physical register address type.
package rename_recovery_sequencer_pkg;

    localparam int unsigned ARCH_W = 5;
    localparam int unsigned PHYS_W = 6;

    typedef logic [PHYS_W-1:0] phys_addr_t;

    // One in-flight rename: which file, which rd, new mapping, replaced mapping.
    typedef struct packed {
        logic              is_fp;
        logic [ARCH_W-1:0] rd;
        phys_addr_t        phys;
        phys_addr_t        prev_phys;
    } rename_journal_entry_t;

    typedef enum logic [1:0] {
        INIT_GP,
        INIT_FP,
        IDLE,
        ROLLBACK
    } rename_seq_state_t;

endpackage

// File: rtl/rename_recovery_sequencer_journal.sv
// Circular journal of in-flight renames.
// Ports: push/push_entry append at the tail; pop_head removes the oldest
// entry (retire); pop_tail removes the youngest entry (rollback).
// head_is_fp/head_prev_phys and tail_entry are combinational reads of the
// oldest and youngest entries; count/full/empty reflect current occupancy.
// pop_tail must not be asserted together with push or pop_head.
module rename_journal
    import rename_recovery_sequencer_pkg::*;
#(
    parameter int unsigned DEPTH = 32,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  rename_journal_entry_t push_entry,
    input  logic                  pop_head,
    input  logic                  pop_tail,
    output logic                  head_is_fp,
    output phys_addr_t            head_prev_phys,
    output rename_journal_entry_t tail_entry,
    output logic [CNT_W-1:0]      count,
    output logic                  full,
    output logic                  empty
);

    rename_journal_entry_t mem_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    rename_journal_entry_t head_entry;

    // Pointer and occupancy update; pointers wrap naturally at DEPTH.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (pop_tail) begin
            tail_d  = tail_q - PTR_W'(1);
            count_d = count_q - CNT_W'(1);
        end else begin
            if (push) tail_d = tail_q + PTR_W'(1);
            if (pop_head) head_d = head_q + PTR_W'(1);
            if (push && !pop_head) begin
                count_d = count_q + CNT_W'(1);
            end else if (!push && pop_head) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage needs no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push) mem_q[tail_q] <= push_entry;
    end

    assign head_entry     = mem_q[head_q];
    assign head_is_fp     = head_entry.is_fp;
    assign head_prev_phys = head_entry.prev_phys;
    assign tail_entry     = mem_q[tail_q - PTR_W'(1)];
    assign count          = count_q;
    assign full           = (count_q == CNT_W'(DEPTH));
    assign empty          = (count_q == '0);

endmodule

// File: rtl/rename_recovery_sequencer.sv
// Control sequencer for the register renamer: post-reset spec-table/free-list
// init, retire-time freeing of the replaced physical register, and flush-time
// rollback walking the rename journal youngest-to-oldest.
// Ports: clk, rst (sync, active-low); rename_* push a journal entry;
// retire_valid commits the oldest entry; flush discards uncommitted entries.
// tbl_* drive the spec-table write port, free_* the GP/FP free-list push
// port; stall, init_done, journal_full are status. All outputs registered.
// Optional macro RENAME_RECOVERY_PERF_EN adds rollback_cycles and
// flush_count saturating performance counters.
module rename_recovery_sequencer
    import rename_recovery_sequencer_pkg::*;
#(
    parameter int unsigned DEPTH      = 32,
    parameter int unsigned INCLUDE_FP = 1,
    parameter int unsigned ARCH_REGS  = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rename_valid,
    input  logic        rename_is_fp,
    input  logic [4:0]  rename_rd,
    input  logic [5:0]  rename_phys,
    input  logic [5:0]  rename_prev_phys,
    input  logic        retire_valid,
    input  logic        flush,
    output logic        tbl_we,
    output logic        tbl_is_fp,
    output logic [4:0]  tbl_waddr,
    output logic [5:0]  tbl_wdata,
    output logic        free_push,
    output logic        free_is_fp,
    output logic [5:0]  free_data,
    output logic        stall,
    output logic        init_done,
`ifdef RENAME_RECOVERY_PERF_EN
    output logic        journal_full,
    output logic [31:0] rollback_cycles,
    output logic [15:0] flush_count
`else
    output logic        journal_full
`endif
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam logic [ARCH_W-1:0] IDX_LAST = ARCH_W'(ARCH_REGS - 1);

    rename_seq_state_t state_q, state_d;
    logic [ARCH_W-1:0] idx_q, idx_d;
    logic              tbl_we_q, tbl_we_d;
    logic              tbl_is_fp_q, tbl_is_fp_d;
    logic [ARCH_W-1:0] tbl_waddr_q, tbl_waddr_d;
    phys_addr_t        tbl_wdata_q, tbl_wdata_d;
    logic              free_push_q, free_push_d;
    logic              free_is_fp_q, free_is_fp_d;
    phys_addr_t        free_data_q, free_data_d;
    logic              stall_q, stall_d;
    logic              init_done_q, init_done_d;
    logic              journal_full_q, journal_full_d;

    logic                  j_push, j_pop_head, j_pop_tail, retire_ok;
    rename_journal_entry_t push_entry, tail_entry;
    logic                  head_is_fp;
    phys_addr_t            head_prev_phys;
    logic [CNT_W-1:0]      j_count;
    logic                  j_full, j_empty;

    assign push_entry = '{is_fp: rename_is_fp, rd: rename_rd,
                          phys: rename_phys, prev_phys: rename_prev_phys};

    rename_journal #(.DEPTH(DEPTH)) u_journal (
        .clk            (clk),
        .rst            (rst),
        .push           (j_push),
        .push_entry     (push_entry),
        .pop_head       (j_pop_head),
        .pop_tail       (j_pop_tail),
        .head_is_fp     (head_is_fp),
        .head_prev_phys (head_prev_phys),
        .tail_entry     (tail_entry),
        .count          (j_count),
        .full           (j_full),
        .empty          (j_empty)
    );

    // Next-state, journal control and next-output logic.
    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        tbl_we_d       = 1'b0;
        tbl_is_fp_d    = 1'b0;
        tbl_waddr_d    = '0;
        tbl_wdata_d    = '0;
        free_push_d    = 1'b0;
        free_is_fp_d   = 1'b0;
        free_data_d    = '0;
        stall_d        = stall_q;
        init_done_d    = init_done_q;
        journal_full_d = j_full;
        j_push         = 1'b0;
        j_pop_head     = 1'b0;
        j_pop_tail     = 1'b0;
        retire_ok      = 1'b0;

        unique case (state_q)
            INIT_GP, INIT_FP: begin
                // Identity map arch reg idx, and hand the upper half to the free list.
                tbl_we_d     = 1'b1;
                tbl_is_fp_d  = (state_q == INIT_FP);
                tbl_waddr_d  = idx_q;
                tbl_wdata_d  = PHYS_W'(idx_q);
                free_push_d  = 1'b1;
                free_is_fp_d = (state_q == INIT_FP);
                free_data_d  = PHYS_W'(ARCH_REGS) + PHYS_W'(idx_q);
                stall_d      = 1'b1;
                if (idx_q == IDX_LAST) begin
                    idx_d   = '0;
                    state_d = (state_q == INIT_GP && INCLUDE_FP != 0) ? INIT_FP : IDLE;
                end else begin
                    idx_d = idx_q + ARCH_W'(1);
                end
            end
            IDLE: begin
                init_done_d = 1'b1;
                stall_d     = 1'b0;
                retire_ok   = retire_valid && !j_empty;
                j_pop_head  = retire_ok;
                if (retire_ok) begin
                    free_push_d  = 1'b1;
                    free_is_fp_d = head_is_fp;
                    free_data_d  = head_prev_phys;
                end
                // A full journal only accepts a rename when a retire frees a slot.
                j_push = rename_valid && !flush && (!j_full || retire_ok);
                if (flush) begin
                    stall_d = 1'b1;
                    state_d = ROLLBACK;
                end
            end
            ROLLBACK: begin
                init_done_d = 1'b1;
                stall_d     = 1'b1;
                if (!j_empty) begin
                    j_pop_tail   = 1'b1;
                    tbl_we_d     = 1'b1;
                    tbl_is_fp_d  = tail_entry.is_fp;
                    tbl_waddr_d  = tail_entry.rd;
                    tbl_wdata_d  = tail_entry.prev_phys;
                    free_push_d  = 1'b1;
                    free_is_fp_d = tail_entry.is_fp;
                    free_data_d  = tail_entry.phys;
                end
                if (j_count <= CNT_W'(1)) state_d = IDLE;
            end
            default: state_d = INIT_GP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= INIT_GP;
            idx_q          <= '0;
            tbl_we_q       <= 1'b0;
            tbl_is_fp_q    <= 1'b0;
            tbl_waddr_q    <= '0;
            tbl_wdata_q    <= '0;
            free_push_q    <= 1'b0;
            free_is_fp_q   <= 1'b0;
            free_data_q    <= '0;
            stall_q        <= 1'b1;
            init_done_q    <= 1'b0;
            journal_full_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            tbl_we_q       <= tbl_we_d;
            tbl_is_fp_q    <= tbl_is_fp_d;
            tbl_waddr_q    <= tbl_waddr_d;
            tbl_wdata_q    <= tbl_wdata_d;
            free_push_q    <= free_push_d;
            free_is_fp_q   <= free_is_fp_d;
            free_data_q    <= free_data_d;
            stall_q        <= stall_d;
            init_done_q    <= init_done_d;
            journal_full_q <= journal_full_d;
        end
    end

    assign tbl_we       = tbl_we_q;
    assign tbl_is_fp    = tbl_is_fp_q;
    assign tbl_waddr    = tbl_waddr_q;
    assign tbl_wdata    = tbl_wdata_q;
    assign free_push    = free_push_q;
    assign free_is_fp   = free_is_fp_q;
    assign free_data    = free_data_q;
    assign stall        = stall_q;
    assign init_done    = init_done_q;
    assign journal_full = journal_full_q;

`ifdef RENAME_RECOVERY_PERF_EN
    logic [31:0] rollback_cycles_q, rollback_cycles_d;
    logic [15:0] flush_count_q, flush_count_d;

    // Saturating counters: cycles spent rolling back, and flushes that started one.
    always_comb begin
        rollback_cycles_d = rollback_cycles_q;
        flush_count_d     = flush_count_q;
        if (state_q == ROLLBACK && rollback_cycles_q != '1) begin
            rollback_cycles_d = rollback_cycles_q + 32'(1);
        end
        if (state_q == IDLE && flush && flush_count_q != '1) begin
            flush_count_d = flush_count_q + 16'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rollback_cycles_q <= '0;
            flush_count_q     <= '0;
        end else begin
            rollback_cycles_q <= rollback_cycles_d;
            flush_count_q     <= flush_count_d;
        end
    end

    assign rollback_cycles = rollback_cycles_q;
    assign flush_count     = flush_count_q;
`endif

`ifndef SYNTHESIS
    // Decode and retire must be quiet while the journal is being unwound.
    always @(posedge clk) begin
        if (rst && state_q == ROLLBACK) begin
            assert (!retire_valid) else $error("retire_valid asserted during rollback");
            assert (!rename_valid) else $error("rename_valid asserted during rollback");
        end
    end
`endif

endmodule

// File: tb/tb_rename_recovery_sequencer.sv
module tb_rename_recovery_sequencer;

    localparam int DEPTH = 32;

    logic       clk = 1'b0;
    logic       rst;
    logic       rename_valid, rename_is_fp, retire_valid, flush;
    logic [4:0] rename_rd;
    logic [5:0] rename_phys, rename_prev_phys;
    logic       tbl_we, tbl_is_fp, free_push, free_is_fp, stall, init_done, journal_full;
    logic [4:0] tbl_waddr;
    logic [5:0] tbl_wdata, free_data;
`ifdef RENAME_RECOVERY_PERF_EN
    logic [31:0] rollback_cycles;
    logic [15:0] flush_count;
`endif

    always #5 clk = ~clk;

    rename_recovery_sequencer #(.DEPTH(DEPTH), .INCLUDE_FP(1), .ARCH_REGS(32)) dut (
        .clk              (clk),
        .rst              (rst),
        .rename_valid     (rename_valid),
        .rename_is_fp     (rename_is_fp),
        .rename_rd        (rename_rd),
        .rename_phys      (rename_phys),
        .rename_prev_phys (rename_prev_phys),
        .retire_valid     (retire_valid),
        .flush            (flush),
        .tbl_we           (tbl_we),
        .tbl_is_fp        (tbl_is_fp),
        .tbl_waddr        (tbl_waddr),
        .tbl_wdata        (tbl_wdata),
        .free_push        (free_push),
        .free_is_fp       (free_is_fp),
        .free_data        (free_data),
        .stall            (stall),
        .init_done        (init_done),
`ifdef RENAME_RECOVERY_PERF_EN
        .journal_full     (journal_full),
        .rollback_cycles  (rollback_cycles),
        .flush_count      (flush_count)
`else
        .journal_full     (journal_full)
`endif
    );

    int nvec = 0;
    int nerr = 0;

    // Reference model: journal as a queue, init as a write counter, rollback as a flag.
    typedef struct {
        logic       fp;
        logic [4:0] rd;
        logic [5:0] ph;
        logic [5:0] pp;
    } ent_t;

    ent_t jq[$];
    int   init_cnt;
    bit   in_init;
    bit   rolling;

    logic       e_tbl_we, e_tbl_fp, e_fpush, e_ffp, e_stall, e_done, e_full;
    logic [4:0] e_waddr;
    logic [5:0] e_wdata, e_fdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("tbl_we", 32'(tbl_we), 32'(e_tbl_we));
        if (e_tbl_we) begin
            chk("tbl_is_fp", 32'(tbl_is_fp), 32'(e_tbl_fp));
            chk("tbl_waddr", 32'(tbl_waddr), 32'(e_waddr));
            chk("tbl_wdata", 32'(tbl_wdata), 32'(e_wdata));
        end
        chk("free_push", 32'(free_push), 32'(e_fpush));
        if (e_fpush) begin
            chk("free_is_fp", 32'(free_is_fp), 32'(e_ffp));
            chk("free_data", 32'(free_data), 32'(e_fdata));
        end
        chk("stall", 32'(stall), 32'(e_stall));
        chk("init_done", 32'(init_done), 32'(e_done));
        chk("journal_full", 32'(journal_full), 32'(e_full));
    endtask

    // Expected registered outputs after the coming edge, from the current inputs.
    task automatic model_cycle(input logic rv, input logic fp, input logic [4:0] rd,
                               input logic [5:0] ph, input logic [5:0] pp,
                               input logic ret, input logic fl);
        ent_t e;
        e_tbl_we = 1'b0; e_tbl_fp = 1'b0; e_waddr = '0; e_wdata = '0;
        e_fpush = 1'b0; e_ffp = 1'b0; e_fdata = '0;
        e_full = (jq.size() == DEPTH);
        if (in_init) begin
            e_tbl_we = 1'b1;
            e_tbl_fp = (init_cnt >= 32);
            e_waddr  = 5'(init_cnt % 32);
            e_wdata  = 6'(init_cnt % 32);
            e_fpush  = 1'b1;
            e_ffp    = e_tbl_fp;
            e_fdata  = 6'(32 + init_cnt % 32);
            e_stall  = 1'b1;
            e_done   = 1'b0;
            init_cnt++;
            if (init_cnt == 64) in_init = 1'b0;
        end else if (rolling) begin
            e_stall = 1'b1;
            e_done  = 1'b1;
            if (jq.size() > 0) begin
                e = jq.pop_back();
                e_tbl_we = 1'b1; e_tbl_fp = e.fp; e_waddr = e.rd; e_wdata = e.pp;
                e_fpush  = 1'b1; e_ffp = e.fp; e_fdata = e.ph;
            end
            if (jq.size() == 0) rolling = 1'b0;
        end else begin
            e_done  = 1'b1;
            e_stall = fl;
            if (ret && jq.size() > 0) begin
                e = jq.pop_front();
                e_fpush = 1'b1; e_ffp = e.fp; e_fdata = e.pp;
            end
            if (rv && !fl && jq.size() < DEPTH) begin
                e.fp = fp; e.rd = rd; e.ph = ph; e.pp = pp;
                jq.push_back(e);
            end
            if (fl) rolling = 1'b1;
        end
    endtask

    task automatic step(input logic rv, input logic fp, input logic [4:0] rd,
                        input logic [5:0] ph, input logic [5:0] pp,
                        input logic ret, input logic fl);
        rename_valid = rv; rename_is_fp = fp; rename_rd = rd;
        rename_phys = ph; rename_prev_phys = pp;
        retire_valid = ret; flush = fl;
        model_cycle(rv, fp, rd, ph, pp, ret, fl);
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 5'd0, 6'd0, 6'd0, 1'b0, 1'b0);
    endtask

    task automatic ren(input logic fp, input logic [4:0] rd, input logic [5:0] ph, input logic [5:0] pp);
        step(1'b1, fp, rd, ph, pp, 1'b0, 1'b0);
    endtask

    task automatic apply_reset(input int n);
        rst = 1'b0;
        rename_valid = 1'b0; rename_is_fp = 1'b0; rename_rd = '0;
        rename_phys = '0; rename_prev_phys = '0; retire_valid = 1'b0; flush = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        in_init = 1'b1; init_cnt = 0; rolling = 1'b0; jq.delete();
        e_tbl_we = 1'b0; e_tbl_fp = 1'b0; e_waddr = '0; e_wdata = '0;
        e_fpush = 1'b0; e_ffp = 1'b0; e_fdata = '0;
        e_stall = 1'b1; e_done = 1'b0; e_full = 1'b0;
        check_all();
        chk("rst_tbl_waddr", 32'(tbl_waddr), 32'd0);
        chk("rst_free_data", 32'(free_data), 32'd0);
        rst = 1'b1;
    endtask

    // Init sequence with random (ignored) traffic on the inputs.
    task automatic run_init();
        for (int i = 0; i < 64; i++) begin
            step(1'($urandom_range(1)), 1'($urandom_range(1)), 5'($urandom_range(31)),
                 6'($urandom_range(63)), 6'($urandom_range(63)),
                 1'($urandom_range(1)), 1'($urandom_range(1)));
        end
    endtask

    initial begin
        apply_reset(2);
        run_init();
        idle(1);
        chk("init_done_after_init", 32'(init_done), 32'd1);
        chk("stall_after_init", 32'(stall), 32'd0);

        // Single rename then retire frees the previous mapping.
        ren(1'b0, 5'd5, 6'd40, 6'd5);
        step(1'b0, 1'b0, 5'd0, 6'd0, 6'd0, 1'b1, 1'b0);
        chk("retire_free_data", 32'(free_data), 32'd5);
        idle(2);

        // Three renames then flush: three rollback writes, youngest first.
        ren(1'b0, 5'd3, 6'd33, 6'd3);
        ren(1'b0, 5'd3, 6'd34, 6'd33);
        ren(1'b1, 5'd7, 6'd40, 6'd7);
        step(1'b0, 1'b0, 5'd0, 6'd0, 6'd0, 1'b0, 1'b1);
        idle(5);

        // Retire and flush together with two entries, plus a dropped rename.
        ren(1'b0, 5'd9, 6'd50, 6'd9);
        ren(1'b1, 5'd2, 6'd51, 6'd2);
        step(1'b1, 1'b0, 5'd4, 6'd52, 6'd4, 1'b1, 1'b1);
        idle(4);

        // Fill the journal across the pointer wrap.
        for (int i = 0; i < DEPTH; i++) begin
            ren(1'($urandom_range(1)), 5'($urandom_range(31, 1)),
                6'($urandom_range(63)), 6'($urandom_range(63)));
        end
        idle(1);
        ren(1'b0, 5'd1, 6'd60, 6'd1);
        step(1'b1, 1'b1, 5'd6, 6'd61, 6'd6, 1'b1, 1'b0);
        idle(1);
        step(1'b0, 1'b0, 5'd0, 6'd0, 6'd0, 1'b0, 1'b1);
        idle(DEPTH + 3);

        // Constrained random traffic; decode and retire stay quiet during rollback.
        for (int c = 0; c < 1500; c++) begin
            if (rolling) begin
                step(1'b0, 1'b0, 5'd0, 6'd0, 6'd0, 1'b0, 1'($urandom_range(3) == 0));
            end else begin
                step(1'($urandom_range(3) != 0), 1'($urandom_range(1)), 5'($urandom_range(31, 1)),
                     6'($urandom_range(63)), 6'($urandom_range(63)),
                     1'($urandom_range(1)), 1'($urandom_range(47) == 0));
            end
        end
        while (rolling) idle(1);
        idle(1);

        // Reset in the middle of a rollback.
        for (int i = 0; i < 6; i++) ren(1'b0, 5'(i + 1), 6'(40 + i), 6'(i + 1));
        step(1'b0, 1'b0, 5'd0, 6'd0, 6'd0, 1'b0, 1'b1);
        idle(2);
        apply_reset(1);
        step(1'b0, 1'b0, 5'd0, 6'd0, 6'd0, 1'b0, 1'b0);
        chk("reinit_first_wdata", 32'(tbl_wdata), 32'd0);
        chk("reinit_first_free", 32'(free_data), 32'd32);
        for (int i = 0; i < 63; i++) idle(1);
        idle(1);
        step(1'b0, 1'b0, 5'd0, 6'd0, 6'd0, 1'b1, 1'b0);
        chk("empty_after_reset", 32'(free_push), 32'd0);
        ren(1'b1, 5'd8, 6'd44, 6'd8);
        step(1'b0, 1'b0, 5'd0, 6'd0, 6'd0, 1'b1, 1'b0);
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
